// File: rtl/vend_pkg.sv
// Shared definitions for the vending change controller: FSM state encoding,
// coin denominations and the product price table.
// No ports; imported by vend_change_ctrl and change_coin_sel.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DISPENSE,
      CHANGE,
      DONE
   } state_t;

   localparam int COIN_1  = 1;
   localparam int COIN_2  = 2;
   localparam int COIN_5  = 5;
   localparam int COIN_10 = 10;

   // Price in NIS for each of the four product slots.
   function automatic int unsigned price_of(input logic [1:0] s);
      int unsigned p;
      case (s)
         2'd0:    p = 5;
         2'd1:    p = 10;
         2'd2:    p = 15;
         default: p = 20;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/change_coin_sel.sv
// Greedy change picker: largest denomination not exceeding the remaining change.
// Purely combinational (zero latency); no flow control.
// Ports: remain (in, TOTAL_W) remaining change; coin (out, COIN_W) coin to emit.
module change_coin_sel
   import vend_pkg::*;
#(
   parameter int TOTAL_W = 5,
   parameter int COIN_W  = 4
) (
   input  logic [TOTAL_W-1:0] remain,
   output logic [COIN_W-1:0]  coin
);

   // Falls through to the 1 NIS coin; the caller only consults this while
   // remain is non-zero, so a 1 coin never overshoots.
   always_comb begin
      coin = COIN_W'(COIN_1);
      if (remain >= TOTAL_W'(COIN_10)) begin
         coin = COIN_W'(COIN_10);
      end else if (remain >= TOTAL_W'(COIN_5)) begin
         coin = COIN_W'(COIN_5);
      end else if (remain >= TOTAL_W'(COIN_2)) begin
         coin = COIN_W'(COIN_2);
      end
   end

endmodule

// File: rtl/vend_change_ctrl.sv
// Vending controller: price check, product release, greedy change payout, credit clear.
// Latency: selection sampled at E0 -> vend after E1 -> first change coin after E2.
// No backpressure: one coin per cycle; all inputs ignored while busy.
// Ports: clk, rst (async, active high); total/sel_valid/sel/cancel from the
// coin accumulator and keypad; busy, vend, vend_item, insufficient,
// change_valid, change_coin, clear_credit decoded from registered state only.
module vend_change_ctrl
   import vend_pkg::*;
#(
   parameter int TOTAL_W = 5,
   parameter int COIN_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [TOTAL_W-1:0] total,
   input  logic               sel_valid,
   input  logic [1:0]         sel,
   input  logic               cancel,
   output logic               busy,
   output logic               vend,
   output logic [1:0]         vend_item,
   output logic               insufficient,
   output logic               change_valid,
   output logic [COIN_W-1:0]  change_coin,
   output logic               clear_credit
);

   state_t             state;
   state_t             state_nxt;
   logic [TOTAL_W-1:0] credit;
   logic [TOTAL_W-1:0] remain;
   logic [TOTAL_W-1:0] price;
   logic [1:0]         item;
   logic [COIN_W-1:0]  coin;
   logic [TOTAL_W-1:0] coin_w;
   logic [TOTAL_W-1:0] diff;

   change_coin_sel #(
      .TOTAL_W (TOTAL_W),
      .COIN_W  (COIN_W)
   ) u_pick (
      .remain (remain),
      .coin   (coin)
   );

   assign coin_w = TOTAL_W'(coin);
   // Only consumed in DISPENSE, which is reachable only when credit >= price.
   assign diff   = credit - price;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // Refund takes priority over a simultaneous selection.
            if (cancel) begin
               state_nxt = (total == '0) ? DONE : CHANGE;
            end else if (sel_valid) begin
               state_nxt = CHECK;
            end
         end
         CHECK:    state_nxt = (credit >= price) ? DISPENSE : IDLE;
         DISPENSE: state_nxt = (diff != '0) ? CHANGE : DONE;
         // The coin being emitted now is the last one when it empties remain.
         CHANGE:   if (remain == coin_w) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit <= '0;
         remain <= '0;
         price  <= '0;
         item   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cancel) begin
                  credit <= total;
                  remain <= total;
               end else if (sel_valid) begin
                  credit <= total;
                  price  <= TOTAL_W'(price_of(sel));
                  item   <= sel;
               end
            end
            DISPENSE: remain <= diff;
            CHANGE:   remain <= remain - coin_w;
            default: ;
         endcase
      end
   end

   assign busy         = (state != IDLE);
   assign vend         = (state == DISPENSE);
   assign vend_item    = vend ? item : 2'b00;
   assign insufficient = (state == CHECK) && (credit < price);
   assign change_valid = (state == CHANGE);
   assign change_coin  = change_valid ? coin : '0;
   assign clear_credit = (state == DONE);

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Self-checking bench for vend_change_ctrl: directed scenarios plus random
// transactions compared cycle by cycle against an arithmetic payout model.
module tb_vend_change_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] total;
   logic       sel_valid;
   logic [1:0] sel;
   logic       cancel;
   logic       busy;
   logic       vend;
   logic [1:0] vend_item;
   logic       insufficient;
   logic       change_valid;
   logic [3:0] change_coin;
   logic       clear_credit;

   int tests_run    = 0;
   int tests_failed = 0;

   vend_change_ctrl #(.TOTAL_W(5), .COIN_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .total        (total),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .busy         (busy),
      .vend         (vend),
      .vend_item    (vend_item),
      .insufficient (insufficient),
      .change_valid (change_valid),
      .change_coin  (change_coin),
      .clear_credit (clear_credit)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Output vector: [10] busy [9] vend [8:7] item [6] insufficient
   //                [5] change_valid [4:1] change_coin [0] clear_credit
   function automatic logic [10:0] pk(input logic b, input logic v, input logic [1:0] it,
                                      input logic ins, input logic cv, input logic [3:0] cn,
                                      input logic clr);
      return {b, v, it, ins, cv, cn, clr};
   endfunction

   function automatic logic [10:0] outs();
      return {busy, vend, vend_item, insufficient, change_valid, change_coin, clear_credit};
   endfunction

   task automatic check(input string tag, input int idx, input logic [10:0] obs,
                        input logic [10:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
      end
   endtask

   // Called at a falling edge with the DUT idle. Presents one request, then
   // checks every following cycle against the model's expected trace. While
   // the DUT is expected busy, inputs are scrambled to show they are ignored.
   task automatic run_txn(input logic [4:0] t, input logic [1:0] s, input logic sv,
                          input logic cn, input int stop_at, input string tag);
      logic [10:0] exp_q[$];
      logic [10:0] obs;
      int          price;
      int          r;
      int          c;
      bit          pay;
      exp_q = {};
      price = 5 * (int'(s) + 1);
      pay   = 1'b0;
      r     = 0;
      if (cn) begin
         pay = 1'b1;
         r   = int'(t);
      end else if (sv) begin
         if (int'(t) < price) begin
            exp_q.push_back(pk(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0));
         end else begin
            exp_q.push_back(pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
            exp_q.push_back(pk(1'b1, 1'b1, s, 1'b0, 1'b0, 4'd0, 1'b0));
            pay = 1'b1;
            r   = int'(t) - price;
         end
      end
      if (pay) begin
         while (r > 0) begin
            c = (r >= 10) ? 10 : (r >= 5) ? 5 : (r >= 2) ? 2 : 1;
            exp_q.push_back(pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 4'(c), 1'b0));
            r -= c;
         end
         exp_q.push_back(pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1));
      end
      exp_q.push_back(pk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));

      total     = t;
      sel       = s;
      sel_valid = sv;
      cancel    = cn;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         obs = outs();
         // vend_item only carries meaning while vend is high.
         if (!exp_q[i][9]) obs[8:7] = 2'b00;
         check(tag, i, obs, exp_q[i]);
         if (stop_at >= 0 && i == stop_at) return;
         if (exp_q[i][10]) begin
            total     = 5'($urandom_range(0, 31));
            sel       = 2'($urandom_range(0, 3));
            sel_valid = 1'($urandom_range(0, 1));
            cancel    = 1'($urandom_range(0, 1));
         end else begin
            sel_valid = 1'b0;
            cancel    = 1'b0;
         end
      end
   endtask

   initial begin
      total     = '0;
      sel       = '0;
      sel_valid = 1'b0;
      cancel    = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      check("reset", 0, outs(), 11'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset", 0, outs(), 11'd0);

      run_txn(5'd23, 2'd1, 1'b1, 1'b0, -1, "sel1_t23");
      run_txn(5'd8,  2'd0, 1'b0, 1'b1, -1, "cancel_t8");
      run_txn(5'd5,  2'd3, 1'b1, 1'b0, -1, "insuff_t5");
      run_txn(5'd15, 2'd2, 1'b1, 1'b0, -1, "exact_t15");
      run_txn(5'd7,  2'd1, 1'b1, 1'b1, -1, "both_t7");
      run_txn(5'd0,  2'd0, 1'b0, 1'b1, -1, "cancel_t0");

      // Reset in the middle of payout, right after the second 10 NIS coin.
      run_txn(5'd31, 2'd0, 1'b1, 1'b0, 3, "rst_mid");
      sel_valid = 1'b0;
      cancel    = 1'b0;
      #1 rst = 1'b1;
      #1 check("rst_async", 0, outs(), 11'd0);
      @(negedge clk);
      check("rst_hold", 0, outs(), 11'd0);
      rst = 1'b0;
      #1 check("rst_release", 0, outs(), 11'd0);
      // First request straight after release is taken at the next edge.
      run_txn(5'd12, 2'd0, 1'b1, 1'b0, -1, "after_rst");

      for (int n = 0; n < 60; n++) begin
         run_txn(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 -1, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
